// File: rtl/mem_stage.sv
// Memory pipeline stage: 3072-word data memory with byte/half/word loads and stores,
// plus a one-cycle register slice carrying PC, instruction, ALU and shifter results.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_PC,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_ALUout,
  input  logic [31:0] in_rt_data,
  input  logic [31:0] in_Shift,
  output logic [31:0] out_PC,
  output logic [31:0] out_instruction,
  output logic [31:0] out_ALUout,
  output logic [31:0] out_DMout,
  output logic [31:0] out_Shift
);

  localparam int unsigned W         = 32;
  localparam int unsigned MEM_WORDS = 3072;
  localparam int unsigned IDX_W     = 12;

  localparam logic [W-1:0] MEM_LIMIT = 32'h0000_3000;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [W-1:0] mem_q [MEM_WORDS];

  logic [W-1:0] pc_q, instr_q, alu_q, dm_q, shift_q;
  logic [W-1:0] pc_d, instr_d, alu_d, dm_d, shift_d;

  logic [5:0]       opcode;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic [W-1:0]     rd_word;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;
  logic             wr_en;
  logic [W-1:0]     wr_word;

  // Address decode and combinational read of the addressed word
  always_comb begin
    opcode   = in_instruction[31:26];
    in_range = (in_ALUout < MEM_LIMIT);
    word_idx = in_ALUout[13:2];
    rd_word  = in_range ? mem_q[word_idx] : '0;
    half_sel = in_ALUout[1] ? rd_word[31:16] : rd_word[15:0];
    case (in_ALUout[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
  end

  // Load extraction and extension; misaligned or non-load yields zero
  always_comb begin
    dm_d = '0;
    case (opcode)
      OP_LW:  if (in_ALUout[1:0] == 2'b00) dm_d = rd_word;
      OP_LH:  if (!in_ALUout[0]) dm_d = {{16{half_sel[15]}}, half_sel};
      OP_LHU: if (!in_ALUout[0]) dm_d = {16'h0000, half_sel};
      OP_LB:  dm_d = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: dm_d = {24'h000000, byte_sel};
      default: dm_d = '0;
    endcase
  end

  // Store merge: the stored lanes replace their part of the current word
  always_comb begin
    wr_en   = 1'b0;
    wr_word = rd_word;
    case (opcode)
      OP_SW: begin
        if (in_ALUout[1:0] == 2'b00) begin
          wr_en   = in_range;
          wr_word = in_rt_data;
        end
      end
      OP_SH: begin
        if (!in_ALUout[0]) begin
          wr_en = in_range;
          if (in_ALUout[1]) wr_word[31:16] = in_rt_data[15:0];
          else              wr_word[15:0]  = in_rt_data[15:0];
        end
      end
      OP_SB: begin
        wr_en = in_range;
        case (in_ALUout[1:0])
          2'd0:    wr_word[7:0]   = in_rt_data[7:0];
          2'd1:    wr_word[15:8]  = in_rt_data[7:0];
          2'd2:    wr_word[23:16] = in_rt_data[7:0];
          default: wr_word[31:24] = in_rt_data[7:0];
        endcase
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_comb begin
    pc_d    = in_PC;
    instr_d = in_instruction;
    alu_d   = in_ALUout;
    shift_d = in_Shift;
  end

  // Reset clears the pipeline register and the whole memory, and drops any store
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      alu_q   <= '0;
      dm_q    <= '0;
      shift_q <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
      dm_q    <= dm_d;
      shift_q <= shift_d;
      if (wr_en) begin
        mem_q[word_idx] <= wr_word;
`ifndef SYNTHESIS
        $display("@%h: *%h <= %h", in_PC, {in_ALUout[31:2], 2'b00}, wr_word);
`endif
      end
    end
  end

  assign out_PC          = pc_q;
  assign out_instruction = instr_q;
  assign out_ALUout      = alu_q;
  assign out_DMout       = dm_q;
  assign out_Shift       = shift_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-addressed reference memory predicts every
// registered output; a monitor compares one cycle after each issued instruction.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_PC, in_instruction, in_ALUout, in_rt_data, in_Shift;
  logic [31:0] out_PC, out_instruction, out_ALUout, out_DMout, out_Shift;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .in_PC           (in_PC),
    .in_instruction  (in_instruction),
    .in_ALUout       (in_ALUout),
    .in_rt_data      (in_rt_data),
    .in_Shift        (in_Shift),
    .out_PC          (out_PC),
    .out_instruction (out_instruction),
    .out_ALUout      (out_ALUout),
    .out_DMout       (out_DMout),
    .out_Shift       (out_Shift)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] sh;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference memory: 0x3000 bytes, little-endian (byte 0 = bits [7:0] of word 0)
  logic [7:0] ref_mem [0:12287];

  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100,
                         LH = 6'b100001, LHU = 6'b100101, SW = 6'b101011,
                         SH = 6'b101001, SB = 6'b101000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a < 32'h3000) begin
      case (op)
        LW:  if (a % 4 == 0) r = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        LH:  if (a % 2 == 0) r = 32'($signed({ref_mem[a+1], ref_mem[a]}));
        LHU: if (a % 2 == 0) r = {16'h0, ref_mem[a+1], ref_mem[a]};
        LB:  r = 32'($signed(ref_mem[a]));
        LBU: r = {24'h0, ref_mem[a]};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic ref_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    if (a < 32'h3000) begin
      if (op == SW && a % 4 == 0) begin
        for (int k = 0; k < 4; k++) ref_mem[a+k] = d[8*k +: 8];
      end else if (op == SH && a % 2 == 0) begin
        ref_mem[a] = d[7:0];
        ref_mem[a+1] = d[15:8];
      end else if (op == SB) begin
        ref_mem[a] = d[7:0];
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expected outputs
  task automatic issue(input logic rst, input logic [31:0] pc, input logic [5:0] op,
                       input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] sh);
    exp_t e;
    logic [31:0] ins;
    @(negedge clk);
    ins = {op, 26'($urandom)};
    reset = rst; in_PC = pc; in_instruction = ins; in_ALUout = alu;
    in_rt_data = rt; in_Shift = sh;
    if (rst) begin
      e = '0;
      for (int i = 0; i < 12288; i++) ref_mem[i] = 8'h00;
    end else begin
      e.pc = pc; e.ins = ins; e.alu = alu; e.sh = sh;
      e.dm = ref_load(op, alu);
      ref_store(op, alu, rt);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled just after the edge that registered the oldest entry
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_PC", out_PC, e.pc);
      check("out_instruction", out_instruction, e.ins);
      check("out_ALUout", out_ALUout, e.alu);
      check("out_DMout", out_DMout, e.dm);
      check("out_Shift", out_Shift, e.sh);
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h3000 + 32'($urandom_range(0, 15));
      1:       return 32'h2FF0 + 32'($urandom_range(0, 15));
      2:       return $urandom;
      default: return 32'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [0:10];
    ops = '{LW, LB, LBU, LH, LHU, SW, SH, SB, 6'h00, 6'h0F, 6'h23 ^ 6'h01};
    return ops[$urandom_range(0, 10)];
  endfunction

  initial begin
    reset = 1'b1; in_PC = '0; in_instruction = '0; in_ALUout = '0;
    in_rt_data = '0; in_Shift = '0;
    for (int i = 0; i < 12288; i++) ref_mem[i] = 8'h00;

    issue(1, 32'h0, 6'h00, 32'h0, 32'h0, 32'h0);
    issue(1, 32'h0, 6'h00, 32'h0, 32'h0, 32'h0);
    // Directed sequence: word, byte and halfword updates of word 0x10
    issue(0, 32'h3000, SW,  32'h10, 32'h12345678, 32'h1);
    issue(0, 32'h3004, LW,  32'h10, 32'h0, 32'h2);
    issue(0, 32'h3008, SB,  32'h11, 32'h000000AB, 32'h3);
    issue(0, 32'h300C, LB,  32'h11, 32'h0, 32'h4);
    issue(0, 32'h3010, LBU, 32'h11, 32'h0, 32'h5);
    issue(0, 32'h3014, LW,  32'h10, 32'h0, 32'h6);
    issue(0, 32'h3018, SH,  32'h12, 32'h00008001, 32'h7);
    issue(0, 32'h301C, LH,  32'h12, 32'h0, 32'h8);
    issue(0, 32'h3020, LHU, 32'h12, 32'h0, 32'h9);
    issue(0, 32'h3024, LW,  32'h10, 32'h0, 32'hA);
    // Misaligned and out-of-range stores leave memory untouched
    issue(0, 32'h3028, SW,  32'h13, 32'hCAFEF00D, 32'hB);
    issue(0, 32'h302C, SW,  32'h3000, 32'hCAFEF00D, 32'hC);
    issue(0, 32'h3030, LW,  32'h10, 32'h0, 32'hD);
    issue(0, 32'h3034, LW,  32'h3000, 32'h0, 32'hE);
    issue(0, 32'h3038, LH,  32'h11, 32'h0, 32'hF);
    issue(0, 32'h303C, LW,  32'h12, 32'h0, 32'h10);
    // Reset during a store discards it and clears memory
    issue(1, 32'h3040, SW,  32'h20, 32'h55AA55AA, 32'h11);
    issue(0, 32'h3044, LW,  32'h10, 32'h0, 32'h12);
    issue(0, 32'h3048, LW,  32'h20, 32'h0, 32'h13);
    // Back-to-back non-memory pass-through
    issue(0, 32'h3004, 6'h00, 32'h10, 32'h0, 32'hDEADBEEF);
    issue(0, 32'h3004, 6'h0F, 32'h10, 32'h0, 32'hDEADBEEF);
    // Top-of-memory boundary
    issue(0, 32'h4000, SW,  32'h2FFC, 32'h89ABCDEF, 32'h0);
    issue(0, 32'h4004, LB,  32'h2FFF, 32'h0, 32'h0);
    issue(0, 32'h4008, LHU, 32'h2FFE, 32'h0, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      issue(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, $urandom, rand_op(),
            rand_addr(), $urandom, $urandom);
    end

    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_PC  input  32  PC of instruction in M stage
- in_instruction  input  32  instruction in M stage
- in_ALUout  input  32  ALU result; byte address for loads/stores
- in_rt_data  input  32  store data, already forwarded upstream
- in_Shift  input  32  shifter result, passed through
- out_PC  output  32  registered PC to Writeback
- out_instruction  output  32  registered instruction to Writeback
- out_ALUout  output  32  registered in_ALUout
- out_DMout  output  32  registered, extended load data
- out_Shift  output  32  registered in_Shift
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL decode opcode in_instruction[31:26]: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sh 101001, sb 101000; any other opcode is neither load nor store.
REQ-004 SHALL contain a data memory of 3072 x 32-bit words, byte range 0x0000_0000-0x0000_2FFF, word index in_ALUout[13:2].
REQ-005 SHALL treat in_ALUout >= 0x3000 as out of range: no write; load data = 0.
REQ-006 SHALL read combinationally in the same cycle and write on the rising edge.
REQ-007 sw SHALL write the full word only when in_ALUout[1:0]==00; misaligned sw writes nothing.
REQ-008 sh SHALL write in_rt_data[15:0] to bits [15:0] if addr[1]==0, else to [31:16], only when addr[0]==0; other bits are preserved.
REQ-009 sb SHALL write in_rt_data[7:0] to byte lane addr[1:0] (lane 0 = bits [7:0]); other bytes are preserved.
REQ-010 Load extension SHALL be: lw = word; lh/lhu = halfword selected by addr[1], sign-/zero-extended; lb/lbu = byte selected by addr[1:0], sign-/zero-extended; misaligned lw/lh/lhu returns 0; non-load returns 0.
REQ-011 Every successful write SHALL print "@<PC hex>: *<word-aligned addr hex> <= <full updated word hex>" in the MIPS convention, printing the whole 32-bit word after the merge.
REQ-012 SHALL register all outputs every cycle with latency 1: each out_* equals the corresponding input, or the extended load result, from the previous cycle.
REQ-013 The stage SHALL not stall; a new instruction is accepted every cycle.
REQ-014 A load in cycle N+1 to the word written in cycle N SHALL return the post-write data.
REQ-015 Out-of-range or misaligned stores SHALL still pass PC, instruction, ALUout and Shift through unchanged.

Reset
REQ-016 While reset=1 at a rising edge, all out_* SHALL become 0x0000_0000.
REQ-017 While reset=1 at a rising edge, every memory word SHALL be cleared to 0, and any store presented in that cycle SHALL be discarded, including its display line.
REQ-018 After reset deasserts, the first instruction SHALL be processed normally in the following cycle.

Verification
REQ-019 Reset, then sw $rt=0x12345678 @0x10, then lw @0x10 -> out_DMout=0x12345678 one cycle after the load; display "@<pc>: *00000010 <= 12345678".
REQ-020 After REQ-019: sb 0xAB @0x11, then lb @0x11 -> 0xFFFFFFAB; lbu @0x11 -> 0x000000AB; word reads 0x1234AB78.
REQ-021 sh 0x8001 @0x12, then lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001; word reads 0x8001AB78.
REQ-022 sw @0x13 (misaligned) and sw @0x3000 (out of range) -> no memory change, no display; lw @0x3000 -> 0.
REQ-023 Assert reset during a sw to 0x20 -> no write; all outputs 0 next cycle; lw @0x10 afterward -> 0.
REQ-024 Back-to-back non-memory instructions with in_Shift=0xDEADBEEF and in_PC=0x3004 -> out_Shift=0xDEADBEEF, out_PC=0x3004 and out_DMout=0 exactly one cycle later.
